// File: rtl/bf16_constants.sv
// rtl/bf16_constants.sv - shared bf16 constants, sigmoid latency default and result-queue entry type
package bf16_constants;

  localparam int PIPE_LAT_DEFAULT = 6;

  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_HALF = 16'h3F00;

  // Wide enough for any practical requester count; the top truncates to its own index width.
  localparam int RSP_ID_W = 8;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [15:0]         data;
  } rsp_entry_t;

endpackage

// File: rtl/sigmoid_pipelined.sv
// rtl/sigmoid_pipelined.sv - bf16 sigmoid, piecewise-linear 0.5 + x/4 clamped to [0,1], fixed latency
module sigmoid_pipelined
  import bf16_constants::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  output logic        valid_out,
  output logic [15:0] data_out
);

  logic [7:0]  exp_in;
  logic [7:0]  mant_in;
  logic [16:0] mag;
  logic [16:0] y_fix;
  logic [4:0]  lead_pos;
  logic [15:0] y_bf16;

  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [15:0]         dat_q [PIPE_LAT];
  logic [15:0]         dat_d [PIPE_LAT];

  // |x|/4 in unsigned Q.16, saturating at 0.5 once |x| >= 2; denormals flush to zero.
  always_comb begin
    exp_in  = data_in[14:7];
    mant_in = {1'b1, data_in[6:0]};
    mag     = '0;
    if (exp_in >= 8'd128) begin
      mag = 17'h08000;
    end else if (exp_in >= 8'd120) begin
      mag = {9'd0, mant_in} << (exp_in - 8'd120);
    end else if (exp_in != 8'd0) begin
      mag = {9'd0, mant_in} >> (8'd120 - exp_in);
    end
    y_fix = data_in[15] ? (17'h08000 - mag) : (17'h08000 + mag);
  end

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < 17; i++) begin
      if (y_fix[i]) lead_pos = 5'(i);
    end
    if (y_fix == '0) begin
      y_bf16 = '0;
    end else begin
      y_bf16 = {1'b0, 8'(8'd111 + {3'd0, lead_pos}),
                7'((y_fix << (5'd16 - lead_pos)) >> 9)};
    end
  end

  always_comb begin
    vld_d[0] = valid_in;
    dat_d[0] = y_bf16;
    for (int k = 1; k < PIPE_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign valid_out = vld_q[PIPE_LAT-1];
  assign data_out  = dat_q[PIPE_LAT-1];

endmodule

// File: rtl/sigmoid_rsp_fifo.sv
// rtl/sigmoid_rsp_fifo.sv - registered result FIFO, no fall-through, head output zeroed while empty
module sigmoid_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (count_q != CNT_W'(DEPTH));
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/sigmoid_arbiter.sv
// rtl/sigmoid_arbiter.sv - round-robin requester arbiter feeding one sigmoid pipe, in-order result FIFO
module sigmoid_arbiter
  import bf16_constants::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int RSP_DEPTH = 8,
  parameter int PIPE_LAT  = PIPE_LAT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*16-1:0]          req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [15:0]                    rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RSP_DEPTH+1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [IDX_W-1:0] tag_q [PIPE_LAT];
  logic [IDX_W-1:0] tag_d [PIPE_LAT];

  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             accept;
  logic             pop;
  logic [15:0]      sig_data_in;
  logic             sig_valid_out;
  logic [15:0]      sig_data_out;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;
  logic [CNT_W-1:0] fifo_count;

  // Gating uses the registered count only, so a pop never frees a slot in its own cycle.
  always_comb begin
    cand_sum    = '0;
    cand        = '0;
    grant_idx   = ptr_q;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      cand = IDX_W'(cand_sum);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    accept    = grant_found && !rst && (outstanding_q < CNT_W'(RSP_DEPTH));
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sig_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) sig_data_in = req_data[16*i +: 16];
    end
  end

  always_comb begin
    rsp_valid = (fifo_count != '0);
    pop       = rsp_valid && rsp_ready;

    ptr_d = ptr_q;
    if (accept) ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);

    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    tag_d[0] = grant_idx;
    for (int k = 1; k < PIPE_LAT; k++) tag_d[k] = tag_q[k-1];

    push_entry.id   = RSP_ID_W'(tag_q[PIPE_LAT-1]);
    push_entry.data = sig_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      outstanding_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      tag_q         <= tag_d;
    end
  end

  sigmoid_pipelined #(
    .PIPE_LAT (PIPE_LAT)
  ) u_sigmoid (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (accept),
    .data_in   (sig_data_in),
    .valid_out (sig_valid_out),
    .data_out  (sig_data_out)
  );

  sigmoid_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sig_valid_out),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  assign rsp_data    = head_entry.data;
  assign rsp_id      = IDX_W'(head_entry.id);
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// tb/tb_sigmoid_arbiter.sv - directed self-checking bench for sigmoid_arbiter
module tb_sigmoid_arbiter;
  import bf16_constants::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic [3:0]  outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sigmoid_arbiter #(
    .NUM_REQ   (4),
    .RSP_DEPTH (8),
    .PIPE_LAT  (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .outstanding (outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int          acc, pops, acc_n, pop_n, out_m;
    int          acc_time [32];
    logic [15:0] bp_vals [3];
    logic [15:0] bp_res [3];
    logic [15:0] rr_res [4];
    logic        exp_rdy, exp_vld;

    bp_vals = '{16'h40E0, 16'hC0E0, 16'h0000};
    bp_res  = '{BF16_ONE, 16'h0000, BF16_HALF};
    rr_res  = '{BF16_HALF, BF16_ONE, 16'h0000, BF16_ONE};
    for (int i = 0; i < 32; i++) acc_time[i] = 0;

    // reset state, with every requester asserting valid
    rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_outstanding", 32'(outstanding), 0);

    // single request, first cycle after reset release
    next_cycle();
    rst = 1'b0; req_valid = 4'b0001; req_data = '0; rsp_ready = 1'b1;
    #1;
    chk("single_grant", 32'(req_ready), 1);
    for (int j = 1; j <= 8; j++) begin
      next_cycle();
      req_valid = '0;
      #1;
      chk("single_rsp_valid", 32'(rsp_valid), (j == 7) ? 1 : 0);
      chk("single_outstanding", 32'(outstanding), (j <= 7) ? 1 : 0);
      if (j == 7) begin
        chk("single_rsp_data", 32'(rsp_data), 32'(BF16_HALF));
        chk("single_rsp_id", 32'(rsp_id), 0);
      end
    end

    // round-robin with all four requesters valid
    next_cycle();
    rst = 1'b1; req_valid = '0;
    req_data = {16'h4120, 16'hC0E0, 16'h40E0, 16'h0000};
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      rst = 1'b0;
      req_valid = (k < 12) ? 4'hF : 4'h0;
      #1;
      chk("rr_grant", 32'(req_ready), (k < 12) ? (1 << (k % 4)) : 0);
      acc  = (k < 12) ? k : 12;
      pops = (k < 7) ? 0 : ((k - 7 < 12) ? k - 7 : 12);
      chk("rr_outstanding", 32'(outstanding), acc - pops);
      chk("rr_rsp_valid", 32'(rsp_valid), (k >= 7 && k <= 18) ? 1 : 0);
      if (k >= 7 && k <= 18) begin
        chk("rr_rsp_id", 32'(rsp_id), (k - 7) % 4);
        chk("rr_rsp_data", 32'(rsp_data), 32'(rr_res[(k - 7) % 4]));
      end
    end

    // backpressure: requester 2 streaming, consumer stalled until cycle 16
    next_cycle();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    acc_n = 0; pop_n = 0; out_m = 0;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      rst = 1'b0;
      rsp_ready = (k >= 16);
      req_valid = (k < 30) ? 4'b0100 : 4'b0000;
      req_data  = {16'h0000, bp_vals[acc_n % 3], 32'h0};
      #1;
      exp_rdy = (k < 30) && (out_m < 8);
      exp_vld = (pop_n < acc_n) && (acc_time[pop_n] + 7 <= k);
      chk("bp_grant", 32'(req_ready), exp_rdy ? 4 : 0);
      chk("bp_outstanding", 32'(outstanding), out_m);
      chk("bp_rsp_valid", 32'(rsp_valid), exp_vld ? 1 : 0);
      if (exp_vld) begin
        chk("bp_rsp_data", 32'(rsp_data), 32'(bp_res[pop_n % 3]));
        chk("bp_rsp_id", 32'(rsp_id), 2);
      end
      if (k == 10) chk("bp_full_outstanding", 32'(outstanding), 8);
      if (k == 16) chk("bp_no_accept_in_full_pop", 32'(req_ready), 0);
      if (k == 18) chk("bp_simul_outstanding", 32'(outstanding), 7);
      if (exp_vld && rsp_ready) begin
        pop_n++;
        out_m--;
      end
      if (exp_rdy) begin
        acc_time[acc_n] = k;
        acc_n++;
        out_m++;
      end
    end

    // value ordering from requester 1
    next_cycle();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      rst = 1'b0;
      req_valid = (k < 2) ? 4'b0010 : 4'b0000;
      req_data  = {32'h0, (k == 0) ? 16'h40E0 : 16'hC0E0, 16'h0};
      #1;
      if (k < 2) chk("ord_grant", 32'(req_ready), 2);
      chk("ord_rsp_valid", 32'(rsp_valid), (k == 7 || k == 8) ? 1 : 0);
      if (k == 7) begin
        chk("ord_first_data", 32'(rsp_data), 32'(BF16_ONE));
        chk("ord_first_id", 32'(rsp_id), 1);
      end
      if (k == 8) begin
        chk("ord_second_data", 32'(rsp_data), 0);
        chk("ord_second_id", 32'(rsp_id), 1);
      end
      if (k == 9) chk("ord_outstanding", 32'(outstanding), 0);
    end

    // reset with three requests in flight
    next_cycle();
    rst = 1'b1; req_valid = '0;
    req_data = {16'h4120, 48'h0};
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      rst = 1'b0;
      req_valid = 4'b1000;
      #1;
      chk("mid_grant", 32'(req_ready), 8);
    end
    next_cycle();
    req_valid = '0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("mid_outstanding", 32'(outstanding), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      #1;
      chk("mid_no_stale_rsp", 32'(rsp_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
